streaming_fifo_occ: RTL and testbench
=====================================

# streaming_fifo_occ

Parametrised AXI-Stream FIFO for dataflow partitions, succeeding the fixed shift-register FIFO wrapper. It buffers a single stream between two layer stages, with configurable data width and depth, including non-power-of-two depths. It reports exact occupancy and registered almost-full/almost-empty flags for backpressure monitoring. An optional high-water-mark counter supports FIFO depth sizing from on-board runs.

## Interface
Parameters:
- WIDTH, 8: stream data width in bits, 1 or more.
- DEPTH, 32: storage entries, 2 or more, any integer.
- AFULL_THRESH, DEPTH-2: almost_full asserts when occupancy is at or above this value; range 1..DEPTH.
- AEMPTY_THRESH, 1: almost_empty asserts when occupancy is at or below this value; range 0..DEPTH-1.

Ports (CW = clog2(DEPTH+1)):
- ap_clk, in, 1: single clock; all logic is on its rising edge.
- ap_rst, in, 1: synchronous, active-high reset.
- in0_V_V_TDATA, in, WIDTH: input stream data.
- in0_V_V_TVALID, in, 1: input valid.
- in0_V_V_TREADY, out, 1: input ready; registered.
- out_V_V_TDATA, out, WIDTH: output stream data.
- out_V_V_TVALID, out, 1: output valid; registered.
- out_V_V_TREADY, in, 1: output ready.
- count, out, CW: current occupancy, 0..DEPTH; registered.
- almost_full, out, 1: registered threshold flag.
- almost_empty, out, 1: registered threshold flag.
- maxcount, out, CW: high-water mark. Present only with the configuration macro.
- maxcount_clr, in, 1: clears the high-water mark. Present only with the configuration macro.

## Operation
- push = in0_V_V_TVALID & in0_V_V_TREADY.
- pop = out_V_V_TVALID & out_V_V_TREADY.
- Storage is a circular buffer with wr_ptr and rd_ptr in the range 0..DEPTH-1. Each pointer wraps from DEPTH-1 to 0 by explicit compare, not by modulo-2^n.
- push writes TDATA to mem[wr_ptr] and advances wr_ptr. pop advances rd_ptr.
- out_V_V_TDATA = mem[rd_ptr], an asynchronous read of stored data. Data is never bypassed from input to output.
- count_next = count + push - pop. Push and pop in the same cycle leave count unchanged.
- Full (count == DEPTH): in0_V_V_TREADY is 0, so no push occurs. A pop is still honoured, and TREADY returns to 1 on the next cycle.
- Empty (count == 0): out_V_V_TVALID is 0. A push makes TVALID 1 on the next cycle.
- in0_V_V_TREADY <= (count_next < DEPTH).
- out_V_V_TVALID <= (count_next > 0).
- almost_full <= (count_next >= AFULL_THRESH).
- almost_empty <= (count_next <= AEMPTY_THRESH).
- AXI rule: while out_V_V_TVALID = 1 and out_V_V_TREADY = 0, out_V_V_TDATA and TVALID stay stable.
- No overflow or underflow path exists, because both handshakes are gated by registered flags.

## Timing
- Reset values: in0_V_V_TREADY = 0, out_V_V_TVALID = 0, count = 0, almost_full = 0, almost_empty = 1, maxcount = 0, both pointers 0. Memory contents are not reset.
- in0_V_V_TREADY rises on the first edge after ap_rst deasserts.
- Reset asserted mid-operation discards all contents on that edge. Handshakes in that same cycle are ignored.
- Latency: a word pushed at edge N is visible with out_V_V_TVALID = 1 after edge N, i.e. available to pop at edge N+1.
- Throughput: one push and one pop per cycle, sustained at any occupancy in 1..DEPTH-1.
- All status outputs reflect state after the current edge; no output has a combinational path from an input.

## Configuration
- STREAMING_FIFO_MAXCOUNT_EN defined:
  - maxcount and maxcount_clr ports exist.
  - maxcount <= maxcount_clr ? count_next : max(maxcount, count_next).
  - Clear and a new maximum in the same cycle yield count_next.
- STREAMING_FIFO_MAXCOUNT_EN undefined: both ports and the register are absent. All other behaviour is identical.

## Structure
- Package streaming_fifo_pkg holds:
  - a constant function cnt_width(depth) returning clog2(depth+1);
  - reset-value constants for the status flags.
- Sub-module streaming_fifo_mem: DEPTH x WIDTH simple dual-port storage with a synchronous write and an asynchronous read port. It holds no control logic, so it maps to distributed RAM or SRL.
- The top level holds the pointers, count, flags and the optional high-water mark.

## Test plan
- Reset, then idle: after ap_rst is released, in0_V_V_TREADY = 1 on the next cycle, count = 0, almost_empty = 1, out_V_V_TVALID = 0.
- Fill with WIDTH=8, DEPTH=5 (non-power-of-two), sink stalled, push 0x01..0x06:
  - 0x01..0x05 are accepted and count = 5;
  - in0_V_V_TREADY = 0 from the cycle after the fifth push, and 0x06 is held by the source;
  - almost_full = 1 from count = 3.
- Wrap-around: sustained push and pop for 20 words with DEPTH=5. Output order equals input order, and count stays constant.
- Simultaneous push and pop when full: the pop is accepted, the push is blocked that cycle, TREADY = 1 on the next cycle, and count goes 5 → 4 → 5.
- Output stall: TVALID = 1 and TREADY = 0 for 3 cycles; TDATA stays unchanged throughout.
- Macro enabled:
  - peak occupancy of 4 followed by drain gives maxcount = 4;
  - asserting maxcount_clr at count = 2 gives maxcount = 2 on the next cycle;
  - asserting ap_rst mid-stream gives count = 0 and maxcount = 0.

Source files
------------

// File: rtl/streaming_fifo_pkg.sv
// streaming_fifo_pkg: shared width helper and status-flag reset values
package streaming_fifo_pkg;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam logic RST_IN_READY  = 1'b0;
  localparam logic RST_OUT_VALID = 1'b0;
  localparam logic RST_AFULL     = 1'b0;
  localparam logic RST_AEMPTY    = 1'b1;

endpackage

// File: rtl/streaming_fifo_mem.sv
// streaming_fifo_mem: DEPTH x WIDTH storage, synchronous write, asynchronous read
module streaming_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // write port; contents are never reset so this maps to LUT RAM or SRL
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/streaming_fifo_occ.sv
// streaming_fifo_occ: AXI-Stream FIFO with occupancy and threshold flags; define STREAMING_FIFO_MAXCOUNT_EN for the high-water mark
module streaming_fifo_occ
  import streaming_fifo_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 32,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst,
  input  logic [WIDTH-1:0]              in0_V_V_TDATA,
  input  logic                          in0_V_V_TVALID,
  output logic                          in0_V_V_TREADY,
  output logic [WIDTH-1:0]              out_V_V_TDATA,
  output logic                          out_V_V_TVALID,
  input  logic                          out_V_V_TREADY,
  output logic [cnt_width(DEPTH)-1:0]   count,
`ifdef STREAMING_FIFO_MAXCOUNT_EN
  output logic [cnt_width(DEPTH)-1:0]   maxcount,
  input  logic                          maxcount_clr,
`endif
  output logic                          almost_full,
  output logic                          almost_empty
);

  localparam int CW = cnt_width(DEPTH);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic          afull_q, afull_d, aempty_q, aempty_d;
  logic          push, pop;

  assign push = in0_V_V_TVALID & in_ready_q;
  assign pop  = out_valid_q & out_V_V_TREADY;

  // pointers wrap at DEPTH-1 by compare so non-power-of-two depths work; flags are precomputed from count_d
  always_comb begin
    wr_ptr_d    = push ? (wr_ptr_q == AW'(DEPTH - 1) ? '0 : wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d    = pop ? (rd_ptr_q == AW'(DEPTH - 1) ? '0 : rd_ptr_q + AW'(1)) : rd_ptr_q;
    count_d     = count_q + CW'(push) - CW'(pop);
    in_ready_d  = count_d < CW'(DEPTH);
    out_valid_d = count_d != '0;
    afull_d     = count_d >= CW'(AFULL_THRESH);
    aempty_d    = count_d <= CW'(AEMPTY_THRESH);
  end

  // state register; reset discards contents and ignores same-cycle handshakes
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= RST_IN_READY;
      out_valid_q <= RST_OUT_VALID;
      afull_q     <= RST_AFULL;
      aempty_q    <= RST_AEMPTY;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
    end
  end

  streaming_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (ap_clk),
    .we    (push & ~ap_rst),
    .waddr (wr_ptr_q),
    .wdata (in0_V_V_TDATA),
    .raddr (rd_ptr_q),
    .rdata (out_V_V_TDATA)
  );

  assign in0_V_V_TREADY = in_ready_q;
  assign out_V_V_TVALID = out_valid_q;
  assign count          = count_q;
  assign almost_full    = afull_q;
  assign almost_empty   = aempty_q;

`ifdef STREAMING_FIFO_MAXCOUNT_EN
  logic [CW-1:0] maxcount_q, maxcount_d;

  // high-water mark; a clear restarts tracking from the post-edge occupancy
  always_comb maxcount_d = (maxcount_clr || count_d > maxcount_q) ? count_d : maxcount_q;

  // high-water mark register
  always_ff @(posedge ap_clk) maxcount_q <= ap_rst ? '0 : maxcount_d;

  assign maxcount = maxcount_q;
`endif

endmodule

// File: tb/tb_streaming_fifo_occ.sv
// tb_streaming_fifo_occ: queue-model bench for streaming_fifo_occ (DEPTH=5), covers STREAMING_FIFO_MAXCOUNT_EN when defined
module tb_streaming_fifo_occ;

  localparam int W  = 8;
  localparam int D  = 5;
  localparam int AF = 3;
  localparam int AE = 1;
  localparam int CW = 3;

  logic          ap_clk = 1'b0;
  logic          ap_rst = 1'b1;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] count;
  logic          afull, aempty;
  logic          maxcount_clr = 1'b0;
`ifdef STREAMING_FIFO_MAXCOUNT_EN
  logic [CW-1:0] maxcount;
`endif

  int tests = 0;
  int fails = 0;

  logic [W-1:0] q[$];
  bit m_live = 0;
  bit m_init = 0;
  int m_max  = 0;

  always #5 ap_clk = ~ap_clk;

  streaming_fifo_occ #(.WIDTH(W), .DEPTH(D), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) dut (
    .ap_clk         (ap_clk),
    .ap_rst         (ap_rst),
    .in0_V_V_TDATA  (in_data),
    .in0_V_V_TVALID (in_valid),
    .in0_V_V_TREADY (in_ready),
    .out_V_V_TDATA  (out_data),
    .out_V_V_TVALID (out_valid),
    .out_V_V_TREADY (out_ready),
    .count          (count),
`ifdef STREAMING_FIFO_MAXCOUNT_EN
    .maxcount       (maxcount),
    .maxcount_clr   (maxcount_clr),
`endif
    .almost_full    (afull),
    .almost_empty   (aempty)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge ap_clk);
  endtask

  // reference: a queue holding the words in flight; ready tracks a one-edge wake-up after reset
  always @(posedge ap_clk) begin
    bit push, pop;
    int s;
    push = m_live && in_valid && q.size() < D;
    pop  = q.size() > 0 && out_ready;
    if (ap_rst) begin
      q.delete();
      m_live = 0;
      m_max  = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(in_data);
      m_live = 1;
      s = q.size();
      m_max = maxcount_clr ? s : (s > m_max ? s : m_max);
    end
    m_init = 1;
  end

  // every-cycle comparison against the queue model
  always @(negedge ap_clk) begin
    if (m_init) begin
      chk("tready", in_ready, m_live && q.size() < D);
      chk("tvalid", out_valid, q.size() > 0);
      chk("count", count, q.size());
      chk("afull", afull, q.size() >= AF);
      chk("aempty", aempty, q.size() <= AE);
      if (q.size() > 0) chk("tdata", out_data, q[0]);
`ifdef STREAMING_FIFO_MAXCOUNT_EN
      chk("maxcount", maxcount, m_max);
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    ap_rst = 1'b0;
    chk("rst_tready", in_ready, 0);
    chk("rst_count", count, 0);
    chk("rst_aempty", aempty, 1);
    chk("rst_tvalid", out_valid, 0);
    tick();
    chk("idle_tready", in_ready, 1);
    chk("idle_count", count, 0);

    for (int k = 1; k <= 5; k++) begin
      int n;
      in_data  = W'(k);
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
        tick();
        n++;
      end
      chk("fill_ready", in_ready, 1);
      tick();
    end
    chk("fill_count", count, 5);
    chk("fill_tready", in_ready, 0);
    chk("fill_afull", afull, 1);
    in_data = 8'h06;
    repeat (2) tick();
    chk("hold_count", count, 5);
    chk("hold_tready", in_ready, 0);

    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("full_pop_count", count, 4);
    chk("full_pop_tready", in_ready, 1);
    tick();
    chk("refill_count", count, 5);
    in_valid = 1'b0;

    repeat (3) begin
      tick();
      chk("stall_tvalid", out_valid, 1);
      chk("stall_tdata", out_data, 8'h02);
    end

    out_ready = 1'b1;
    begin
      int n = 0;
      while (count != 0 && n < 20) begin
        tick();
        n++;
      end
    end
    out_ready = 1'b0;
    chk("drain_count", count, 0);

    in_data  = 8'h40;
    in_valid = 1'b1;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = W'(8'h41 + i);
      tick();
      chk("wrap_count", count, 1);
      chk("wrap_data", out_data, 8'h41 + i);
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("wrap_empty", count, 0);

`ifdef STREAMING_FIFO_MAXCOUNT_EN
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    tick();
    chk("hwm_rst", maxcount, 0);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = W'(8'h80 + i);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    chk("hwm_drain_count", count, 0);
    chk("hwm_peak", maxcount, 4);
    in_valid = 1'b1;
    repeat (2) tick();
    in_valid = 1'b0;
    chk("hwm_count2", count, 2);
    maxcount_clr = 1'b1;
    tick();
    maxcount_clr = 1'b0;
    chk("hwm_clr", maxcount, 2);
    in_valid = 1'b1;
    repeat (2) tick();
    out_ready = 1'b1;
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("hwm_midrst_count", count, 0);
    chk("hwm_midrst_max", maxcount, 0);
`endif

    for (int i = 0; i < 800; i++) begin
      bit fill_bias;
      fill_bias    = ((i / 100) % 2) == 0;
      in_data      = W'($urandom);
      in_valid     = fill_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      out_ready    = fill_bias ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      maxcount_clr = $urandom_range(0, 15) == 0;
      ap_rst       = $urandom_range(0, 249) == 0;
      tick();
    end
    ap_rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    maxcount_clr = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
